// File: rtl/prcoder_pkg.sv
// Shared types for the priority encoder / one-hot pulse decoder pair.
// Code index, one-hot line vector and decoder FSM states.
package prcoder_pkg;

  typedef logic [2:0] code_t;
  typedef logic [7:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } dec_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 line decoder with enable.
// Output is all-zero when disabled, otherwise exactly one bit set.
import prcoder_pkg::*;

module dec3to8 (
  input  code_t code,
  input  logic  en,
  output line_t line
);

  // Select the single line addressed by code
  always_comb begin
    line = '0;
    if (en) line[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_pulse_dec8.sv
// Valid/ready code sink that strobes one of eight lines for PULSE_LEN
// cycles, then idles GAP_LEN cycles; counts accepted codes.
import prcoder_pkg::*;

module onehot_pulse_dec8 #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [2:0] code,
  input  logic       code_none,
  output logic       code_ready,
  output logic [7:0] onehot,
  output logic       busy,
  output logic       done,
  output logic [7:0] tx_count
);

  localparam int CNT_W = $clog2(max2(PULSE_LEN, GAP_LEN) + 1);
  localparam bit HAS_GAP = (GAP_LEN > 0);
  localparam logic [CNT_W-1:0] PULSE_INI = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INI =
    CNT_W'(HAS_GAP ? GAP_LEN - 1 : 0);

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  line_t            oh_q, oh_d;
  logic             done_q, done_d;
  logic [7:0]       tx_q, tx_d;
  line_t            dec_line;
  logic             accept;

  assign code_ready = (state_q == IDLE) & ~rst;
  assign accept     = code_valid & code_ready;
  assign busy       = (state_q != IDLE);
  assign onehot     = oh_q;
  assign done       = done_q;
  assign tx_count   = tx_q;

  dec3to8 u_dec (
    .code (code),
    .en   (~code_none),
    .line (dec_line)
  );

  // Next-state: accept, pulse countdown, gap countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oh_d    = oh_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PULSE;
          cnt_d   = PULSE_INI;
          oh_d    = dec_line;
          tx_d    = tx_q + 8'd1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          oh_d = '0;
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = GAP_INI;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        oh_d    = '0;
      end
    endcase
  end

  // State, counter, strobe and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oh_q    <= '0;
      done_q  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oh_q    <= oh_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_onehot_pulse_dec8.sv
// Randomized bench for onehot_pulse_dec8 against a timeline model:
// each accept at edge N defines all outputs as a function of (edge - N).
module tb_onehot_pulse_dec8;

  localparam int PA = 4;
  localparam int GA = 2;
  localparam int PB = 1;
  localparam int GB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_valid, a_none, a_ready, a_busy, a_done;
  logic [2:0] a_code;
  logic [7:0] a_oh, a_txc;
  logic       b_rst, b_valid, b_none, b_ready, b_busy, b_done;
  logic [2:0] b_code;
  logic [7:0] b_oh, b_txc;

  onehot_pulse_dec8 #(.PULSE_LEN(PA), .GAP_LEN(GA)) u_a (
    .clk(clk), .rst(a_rst), .code_valid(a_valid), .code(a_code),
    .code_none(a_none), .code_ready(a_ready), .onehot(a_oh),
    .busy(a_busy), .done(a_done), .tx_count(a_txc)
  );

  onehot_pulse_dec8 #(.PULSE_LEN(PB), .GAP_LEN(GB)) u_b (
    .clk(clk), .rst(b_rst), .code_valid(b_valid), .code(b_code),
    .code_none(b_none), .code_ready(b_ready), .onehot(b_oh),
    .busy(b_busy), .done(b_done), .tx_count(b_txc)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int a_acc = -1;
  int b_acc = -1;
  logic [7:0] a_mask = 8'h0, b_mask = 8'h0;
  logic [7:0] a_tx = 8'h0, b_tx = 8'h0;

  function automatic logic m_busy(input int acc, input int n, input int len);
    return (acc >= 0) && (n - acc < len);
  endfunction

  function automatic logic [18:0] exp_a();
    logic bz, dn;
    logic [7:0] oh;
    bz = m_busy(a_acc, edge_n, PA + GA);
    dn = (a_acc >= 0) && (edge_n - a_acc == PA + GA);
    oh = m_busy(a_acc, edge_n, PA) ? a_mask : 8'h0;
    return {!bz && !a_rst, bz, dn, oh, a_tx};
  endfunction

  function automatic logic [18:0] exp_b();
    logic bz, dn;
    logic [7:0] oh;
    bz = m_busy(b_acc, edge_n, PB + GB);
    dn = (b_acc >= 0) && (edge_n - b_acc == PB + GB);
    oh = m_busy(b_acc, edge_n, PB) ? b_mask : 8'h0;
    return {!bz && !b_rst, bz, dn, oh, b_tx};
  endfunction

  task automatic tick();
    logic aa, ab;
    aa = a_valid && !a_rst && !m_busy(a_acc, edge_n, PA + GA);
    ab = b_valid && !b_rst && !m_busy(b_acc, edge_n, PB + GB);
    @(posedge clk);
    edge_n++;
    if (a_rst) begin
      a_acc = -1; a_tx = 8'h0;
    end else if (aa) begin
      a_acc = edge_n;
      a_mask = a_none ? 8'h0 : 8'(1 << a_code);
      a_tx = a_tx + 8'd1;
    end
    if (b_rst) begin
      b_acc = -1; b_tx = 8'h0;
    end else if (ab) begin
      b_acc = edge_n;
      b_mask = b_none ? 8'h0 : 8'(1 << b_code);
      b_tx = b_tx + 8'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; a_valid = 1; b_valid = 1;
    a_code = 3'd5; b_code = 3'd5; a_none = 0; b_none = 0;
    repeat (2) begin
      tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== 19'h0) begin
        errors++;
        $display("FAIL reset_a got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, 19'h0);
      end
      checks++;
      if ({b_ready, b_busy, b_done, b_oh, b_txc} !== 19'h0) begin
        errors++;
        $display("FAIL reset_b got=%h exp=%h",
          {b_ready, b_busy, b_done, b_oh, b_txc}, 19'h0);
      end
      checks++;
    end
    a_rst = 0; b_rst = 0; a_valid = 0; b_valid = 0;
    tick();
    if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
      errors++;
      $display("FAIL reset_rel got=%h exp=%h",
        {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
    end
    checks++;
  endtask

  task automatic test_single();
    int hi = 0;
    int dn = 0;
    a_code = 3'd5; a_none = 0; a_valid = 1;
    tick();
    a_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
        errors++;
        $display("FAIL single got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
      end
      checks++;
      if (a_oh == 8'h20) hi++;
      if (a_done) dn++;
    end
    if (hi != 4 || dn != 1 || a_txc !== 8'd1 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_sum got hi=%0d done=%0d tx=%0d rdy=%b exp 4 1 1 1",
        hi, dn, a_txc, a_ready);
    end
    checks++;
  endtask

  task automatic test_sweep();
    int idx = 0;
    int last = -1;
    logic [7:0] prev = 8'h0;
    logic [7:0] want;
    a_code = 3'd0; a_none = 0; a_valid = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
        errors++;
        $display("FAIL sweep got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
      end
      checks++;
      if (prev == 8'h0 && a_oh != 8'h0) begin
        want = 8'h1;
        want = want << idx;
        if (a_oh !== want || (last >= 0 && edge_n - last != 7)) begin
          errors++;
          $display("FAIL sweep_step got=%h gap=%0d exp=%h gap=7",
            a_oh, edge_n - last, want);
        end
        checks++;
        last = edge_n;
        idx++;
      end
      prev = a_oh;
      if (a_acc == edge_n) begin
        if (a_code == 3'd7) a_valid = 0;
        else a_code = a_code + 3'd1;
      end
    end
    if (idx != 8 || a_txc !== 8'd9) begin
      errors++;
      $display("FAIL sweep_sum got strobes=%0d tx=%0d exp 8 9", idx, a_txc);
    end
    checks++;
  endtask

  task automatic test_none();
    int seen = 0;
    int dn = 0;
    a_code = 3'd3; a_none = 1; a_valid = 1;
    tick();
    a_valid = 0; a_none = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
        errors++;
        $display("FAIL none got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
      end
      checks++;
      if (a_oh != 8'h0) seen++;
      if (a_done) dn++;
    end
    if (seen != 0 || dn != 1 || a_txc !== 8'd10) begin
      errors++;
      $display("FAIL none_sum got lit=%0d done=%0d tx=%0d exp 0 1 10",
        seen, dn, a_txc);
    end
    checks++;
  endtask

  task automatic test_abort();
    int dn = 0;
    a_code = 3'd7; a_none = 0; a_valid = 1;
    tick();
    a_valid = 0;
    tick();
    if (a_oh !== 8'h80) begin
      errors++;
      $display("FAIL abort_pre got=%h exp=%h", a_oh, 8'h80);
    end
    checks++;
    a_rst = 1;
    tick();
    a_rst = 0;
    if (a_oh !== 8'h0 || a_txc !== 8'h0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort got oh=%h tx=%h busy=%b exp 00 00 0",
        a_oh, a_txc, a_busy);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
        errors++;
        $display("FAIL abort_after got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
      end
      checks++;
      if (a_done) dn++;
    end
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_done got=%0d exp=0", dn);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || a_acc == edge_n) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_code = 3'($urandom_range(0, 7));
        a_none = ($urandom_range(0, 5) == 0);
      end
      tick();
      if ({a_ready, a_busy, a_done, a_oh, a_txc} !== exp_a()) begin
        errors++;
        $display("FAIL random got=%h exp=%h",
          {a_ready, a_busy, a_done, a_oh, a_txc}, exp_a());
      end
      checks++;
    end
    a_valid = 0;
  endtask

  task automatic test_back_to_back();
    int nacc = 0;
    b_valid = 1; b_none = 0;
    b_code = 3'($urandom_range(0, 7));
    for (int i = 0; i < 700 && nacc < 256; i++) begin
      tick();
      if ({b_ready, b_busy, b_done, b_oh, b_txc} !== exp_b()) begin
        errors++;
        $display("FAIL b2b got=%h exp=%h",
          {b_ready, b_busy, b_done, b_oh, b_txc}, exp_b());
      end
      checks++;
      if (b_acc == edge_n) nacc++;
      b_code = 3'($urandom_range(0, 7));
    end
    b_valid = 0;
    tick();
    if (nacc != 256 || b_txc !== 8'h0 || b_oh !== 8'h0) begin
      errors++;
      $display("FAIL b2b_wrap got acc=%0d tx=%0d oh=%h exp 256 0 00",
        nacc, b_txc, b_oh);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_none();
    test_abort();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
